// File: rtl/binary2bcd_seq_dabble.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input: define BIN2BCD_SIGNED_EN.
module binary2bcd_seq_dabble #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   packed_bcd,
    output logic [8*DIGITS-1:0]   unpacked_bcd,
    output logic                  overflow,
    output logic                  sign_out,
    output logic                  busy
);

    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [BIN_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic [8*DIGITS-1:0] unp_nxt;
    logic                ovf_q;
    logic                ovf_nxt;
    logic [CW-1:0]       cnt;
    logic [BIN_W-1:0]    load_val;
    logic                last;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_SHIFT);
    assign out_valid = (state == S_DONE);
    assign last      = (cnt == CW'(1));

`ifdef BIN2BCD_SIGNED_EN
    // Magnitude of the two's-complement input; the most negative value wraps to 2^(BIN_W-1)
    always_comb begin
        load_val = binary_in;
        if (binary_in[BIN_W-1])
            load_val = (~binary_in) + BIN_W'(1);
    end
`else
    assign load_val = binary_in;
`endif

    // Add-3 correction on every digit >= 5, then shift one binary bit in
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_nxt = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        ovf_nxt = ovf_q | bcd_adj[4*DIGITS-1];
    end

    // Byte-per-digit view of the final shift result
    always_comb begin
        unp_nxt = '0;
        for (int d = 0; d < DIGITS; d++)
            unp_nxt[8*d +: 4] = bcd_nxt[4*d +: 4];
    end

    // Control FSM and working shift registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_q <= load_val;
                        bcd_q <= '0;
                        ovf_q <= 1'b0;
                        cnt   <= CW'(BIN_W);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    bcd_q <= bcd_nxt;
                    ovf_q <= ovf_nxt;
                    cnt   <= cnt - CW'(1);
                    if (last)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers only move when the last shift completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            packed_bcd   <= '0;
            unpacked_bcd <= '0;
            overflow     <= 1'b0;
        end else if (state == S_SHIFT && last) begin
            packed_bcd   <= bcd_nxt;
            unpacked_bcd <= unp_nxt;
            overflow     <= ovf_nxt;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q;

    // Sign captured with the input, published alongside the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            sign_out <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid)
                sign_q <= binary_in[BIN_W-1];
            if (state == S_SHIFT && last)
                sign_out <= sign_q;
        end
    end
`else
    assign sign_out = 1'b0;
`endif

endmodule

// File: tb/tb_binary2bcd_seq_dabble.sv
// Bench for binary2bcd_seq_dabble: directed and randomized conversions
// checked against an arithmetic decimal model.
module tb_binary2bcd_seq_dabble;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  binary_in = '0;
    logic        in_ready, out_valid, overflow, sign_out, busy;
    logic [11:0] packed_bcd;
    logic [23:0] unpacked_bcd;

    logic        b_in_ready, b_out_valid, b_overflow, b_sign_out, b_busy;
    logic [7:0]  b_packed;
    logic [15:0] b_unpacked;

    logic        c_in_valid = 1'b0;
    logic        c_out_ready = 1'b0;
    logic [15:0] c_bin = '0;
    logic        c_in_ready, c_out_valid, c_overflow, c_sign_out, c_busy;
    logic [19:0] c_packed;
    logic [39:0] c_unpacked;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    binary2bcd_seq_dabble #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .binary_in(binary_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .packed_bcd(packed_bcd), .unpacked_bcd(unpacked_bcd),
        .overflow(overflow), .sign_out(sign_out), .busy(busy)
    );

    binary2bcd_seq_dabble #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .binary_in(binary_in),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .packed_bcd(b_packed), .unpacked_bcd(b_unpacked),
        .overflow(b_overflow), .sign_out(b_sign_out), .busy(b_busy)
    );

    binary2bcd_seq_dabble #(.BIN_W(16), .DIGITS(5)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .binary_in(c_bin),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .packed_bcd(c_packed), .unpacked_bcd(c_unpacked),
        .overflow(c_overflow), .sign_out(c_sign_out), .busy(c_busy)
    );

    function automatic longint unsigned mag(input longint unsigned x, input int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        x = x & m;
`ifdef BIN2BCD_SIGNED_EN
        if (((x >> (w - 1)) & 64'd1) != 0)
            return (64'd1 << w) - x;
`endif
        return x;
    endfunction

    function automatic logic sgn(input longint unsigned x, input int w);
`ifdef BIN2BCD_SIGNED_EN
        return ((x >> (w - 1)) & 64'd1) != 0;
`else
        return (w < 0);
`endif
    endfunction

    function automatic logic [63:0] pk(input longint unsigned v, input int d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < d; k++) begin
            r = r | (64'(v % 10) << (4 * k));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] unp(input longint unsigned v, input int d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < d; k++) begin
            r = r | (64'(v % 10) << (8 * k));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ovf(input longint unsigned v, input int d);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < d; k++)
            p = p * 10;
        return v >= p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic convert8(input logic [7:0] x, input bit stall, output logic [11:0] got);
        int n;
        longint unsigned v;
        v = mag(64'(x), 8);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        binary_in = x;
        out_ready = !stall;
        @(negedge clk);
        in_valid  = 1'b0;
        binary_in = 8'($urandom);
        chk("busy", 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd8);
        chk("packed", 64'(packed_bcd), pk(v, 3));
        chk("unpacked", 64'(unpacked_bcd), unp(v, 3));
        chk("overflow", 64'(overflow), 64'(ovf(v, 3)));
        chk("sign", 64'(sign_out), 64'(sgn(64'(x), 8)));
        chk("b_packed", 64'(b_packed), pk(v, 2));
        chk("b_overflow", 64'(b_overflow), 64'(ovf(v, 2)));
        chk("ready_done", 64'(in_ready), 64'd0);
        got = packed_bcd;
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                in_valid  = 1'b1;
                binary_in = 8'($urandom);
                @(negedge clk);
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(packed_bcd), pk(v, 3));
                chk("stall_ready", 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("drain_ready", 64'(in_ready), 64'd1);
        chk("drain_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic convert16(input logic [15:0] x);
        int n;
        longint unsigned v;
        v = mag(64'(x), 16);
        n = 0;
        while (!c_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        c_in_valid  = 1'b1;
        c_bin       = x;
        c_out_ready = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
        n = 0;
        while (!c_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("c_latency", 64'(n), 64'd16);
        chk("c_packed", 64'(c_packed), pk(v, 5));
        chk("c_unpacked", 64'(c_unpacked), unp(v, 5));
        chk("c_overflow", 64'(c_overflow), 64'(ovf(v, 5)));
        chk("c_sign", 64'(c_sign_out), 64'(sgn(64'(x), 16)));
        @(negedge clk);
        chk("c_drain_ready", 64'(c_in_ready), 64'd1);
    endtask

    initial begin
        logic [11:0] got;
        int seen;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_packed", 64'(packed_bcd), 64'd0);
        chk("rst_unpacked", 64'(unpacked_bcd), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_sign", 64'(sign_out), 64'd0);

`ifdef BIN2BCD_SIGNED_EN
        convert8(8'h80, 1'b0, got);
        chk("s80_packed", 64'(got), 64'h128);
        chk("s80_sign", 64'(sign_out), 64'd1);
        convert8(8'hFF, 1'b0, got);
        chk("sff_packed", 64'(got), 64'h001);
        chk("sff_sign", 64'(sign_out), 64'd1);
        convert8(8'h7F, 1'b0, got);
        chk("s7f_packed", 64'(got), 64'h127);
        chk("s7f_sign", 64'(sign_out), 64'd0);
`else
        convert8(8'hFF, 1'b0, got);
        chk("ff_packed", 64'(got), 64'h255);
        chk("ff_unpacked", 64'(unpacked_bcd), 64'h020505);
        chk("ff_overflow", 64'(overflow), 64'd0);
        convert8(8'h00, 1'b0, got);
        chk("b2b_00", 64'(got), 64'h000);
        convert8(8'h63, 1'b0, got);
        chk("b2b_63", 64'(got), 64'h099);
        convert8(8'h0A, 1'b0, got);
        chk("b2b_0a", 64'(got), 64'h010);
        convert8(8'd163, 1'b1, got);
        chk("stall_163", 64'(got), 64'h163);
        convert8(8'd200, 1'b0, got);
        chk("d2_200_ovf", 64'(b_overflow), 64'd1);
        convert8(8'd99, 1'b0, got);
        chk("d2_99_ovf", 64'(b_overflow), 64'd0);
        chk("d2_99_packed", 64'(b_packed), 64'h99);
`endif

        in_valid  = 1'b1;
        binary_in = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_packed", 64'(packed_bcd), 64'd0);
        chk("mid_rst_unpacked", 64'(unpacked_bcd), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_sign", 64'(sign_out), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid)
                seen++;
        end
        chk("mid_rst_no_valid", 64'(seen), 64'd0);
        convert8(8'h2A, 1'b0, got);
        chk("after_rst_2a", 64'(got), 64'h042);

        for (int i = 0; i < 256; i++)
            convert8(8'(i), 1'b0, got);

        for (int i = 0; i < 40; i++)
            convert8(8'($urandom), ($urandom % 4) == 0, got);

        convert16(16'hFFFF);
`ifndef BIN2BCD_SIGNED_EN
        chk("c_65535", 64'(c_packed), 64'h65535);
`endif
        convert16(16'h0000);
        for (int i = 0; i < 30; i++)
            convert16(16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
